line_buf3: RTL and testbench



---
 rtl/line_buf3_pkg.sv | 25 ++
 rtl/line_buf3_if.sv | 44 ++++
 rtl/line_buf3_line_mem.sv | 30 +++
 rtl/line_buf3.sv | 184 ++++++++++++++++++
 tb/tb_line_buf3.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/line_buf3_pkg.sv
// linebuf_pkg: shared types and constants for the line_buf3 window feeder.
// Holds the FSM state type, default geometry and the counter width helper.
// Optional feature macro used by the slice: LINEBUF_SOF_EN (adds sof input).
package linebuf_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_IMG_WIDTH   = 640;
  localparam int DEF_IMG_HEIGHT  = 480;

  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    STREAM = 2'd2
  } lb_state_e;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      cnt_width = 1;
    end else begin
      cnt_width = $clog2(n);
    end
  endfunction

endpackage

// File: rtl/line_buf3_if.sv
// line_buf3_if: pixel input handshake and column-triple output bundle.
// The slave modport is the line buffer's view, master is the source/sink side.
// With LINEBUF_SOF_EN defined the bundle also carries the sof strobe.
interface line_buf3_if
  import linebuf_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
);

  logic                   in_valid;
  logic                   in_ready;
  logic [PIXEL_WIDTH-1:0] pixel_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [PIXEL_WIDTH-1:0] pix_top;
  logic [PIXEL_WIDTH-1:0] pix_mid;
  logic [PIXEL_WIDTH-1:0] pix_bot;
  logic                   out_sol;
  logic                   out_eof;
`ifdef LINEBUF_SOF_EN
  logic                   sof;

  modport slave (
    input  in_valid, pixel_in, out_ready, sof,
    output in_ready, out_valid, pix_top, pix_mid, pix_bot, out_sol, out_eof
  );

  modport master (
    output in_valid, pixel_in, out_ready, sof,
    input  in_ready, out_valid, pix_top, pix_mid, pix_bot, out_sol, out_eof
  );
`else
  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, pix_top, pix_mid, pix_bot, out_sol, out_eof
  );

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, pix_top, pix_mid, pix_bot, out_sol, out_eof
  );
`endif

endinterface

// File: rtl/line_buf3_line_mem.sv
// line_mem: single-port DEPTH x WIDTH line memory.
// The read port is combinational so the word seen in a cycle is the value
// before that cycle's write (read-before-write at the same address).
// Contents are deliberately not reset; priming overwrites every entry.
module line_mem
  import linebuf_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int WIDTH = DEF_PIXEL_WIDTH,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Synchronous write of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buf3.sv
// line_buf3: raster-to-column window feeder for the 3x3 convolution stage.
// Two line memories hold rows r-2 and r-1; every accepted pixel of row 2
// onward produces a {top, mid, bot} column triple in a one-entry register.
// Optional feature: define LINEBUF_SOF_EN to add a sof input that forces the
// accepted pixel to row 0, col 0 and restarts priming.
module line_buf3
  import linebuf_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
  input logic        clk,
  input logic        rst,
  line_buf3_if.slave bus
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  lb_state_e              state_r;
  lb_state_e              state_nxt_s;
  logic [CW-1:0]          col_r;
  logic [CW-1:0]          col_nxt_s;
  logic [CW-1:0]          addr_s;
  logic [RW-1:0]          row_r;
  logic [RW-1:0]          row_nxt_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   sof_hit_s;
  logic                   last_col_s;
  logic                   last_row_s;
  logic                   load_s;
  logic [PIXEL_WIDTH-1:0] lb0_rd_s;
  logic [PIXEL_WIDTH-1:0] lb1_rd_s;

  logic                   out_valid_r;
  logic                   out_sol_r;
  logic                   out_eof_r;
  logic [PIXEL_WIDTH-1:0] pix_top_r;
  logic [PIXEL_WIDTH-1:0] pix_mid_r;
  logic [PIXEL_WIDTH-1:0] pix_bot_r;

`ifdef LINEBUF_SOF_EN
  assign sof_hit_s = accept_s && bus.sof;
`else
  assign sof_hit_s = 1'b0;
`endif

  assign accept_s   = bus.in_valid && in_ready_s;
  assign last_col_s = (col_r == COL_LAST);
  assign last_row_s = (row_r == ROW_LAST);
  // A sof pixel takes column 0 regardless of where the counter was.
  assign addr_s     = sof_hit_s ? {CW{1'b0}} : col_r;
  assign load_s     = accept_s && !sof_hit_s && (state_r == STREAM);

  // Priming always accepts; streaming accepts when the output slot frees up.
  always_comb begin
    in_ready_s = 1'b1;
    if (state_r == STREAM) begin
      in_ready_s = !out_valid_r || bus.out_ready;
    end else begin
      in_ready_s = 1'b1;
    end
  end

  // Column/row counters advance on accept; sof restarts them at col 1.
  always_comb begin
    col_nxt_s = col_r;
    row_nxt_s = row_r;
    if (sof_hit_s) begin
      col_nxt_s = CW'(1);
      row_nxt_s = {RW{1'b0}};
    end else if (accept_s && last_col_s) begin
      col_nxt_s = {CW{1'b0}};
      row_nxt_s = last_row_s ? {RW{1'b0}} : row_r + RW'(1);
    end else if (accept_s) begin
      col_nxt_s = col_r + CW'(1);
    end else begin
      col_nxt_s = col_r;
      row_nxt_s = row_r;
    end
  end

  // FSM next state: two priming rows, then stream until the frame's last pixel.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      PRIME0: begin
        if (accept_s && last_col_s) begin
          state_nxt_s = PRIME1;
        end else begin
          state_nxt_s = PRIME0;
        end
      end
      PRIME1: begin
        if (accept_s && last_col_s) begin
          state_nxt_s = STREAM;
        end else begin
          state_nxt_s = PRIME1;
        end
      end
      STREAM: begin
        if (accept_s && last_col_s && last_row_s) begin
          state_nxt_s = PRIME0;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      default: begin
        state_nxt_s = PRIME0;
      end
    endcase
    if (sof_hit_s) begin
      state_nxt_s = PRIME0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State and position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PRIME0;
      col_r   <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      col_r   <= col_nxt_s;
      row_r   <= row_nxt_s;
    end
  end

  // One-entry output register: load on stream accept, drop on pop, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sol_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      pix_top_r   <= {PIXEL_WIDTH{1'b0}};
      pix_mid_r   <= {PIXEL_WIDTH{1'b0}};
      pix_bot_r   <= {PIXEL_WIDTH{1'b0}};
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_sol_r   <= (col_r == {CW{1'b0}});
      out_eof_r   <= last_col_s && last_row_s;
      pix_top_r   <= lb0_rd_s;
      pix_mid_r   <= lb1_rd_s;
      pix_bot_r   <= bus.pixel_in;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // lb0 receives the row leaving lb1; lb1 receives the incoming pixel.
  line_mem #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (addr_s),
    .wdata (lb1_rd_s),
    .rdata (lb0_rd_s)
  );

  line_mem #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (addr_s),
    .wdata (bus.pixel_in),
    .rdata (lb1_rd_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sol   = out_sol_r;
  assign bus.out_eof   = out_eof_r;
  assign bus.pix_top   = pix_top_r;
  assign bus.pix_mid   = pix_mid_r;
  assign bus.pix_bot   = pix_bot_r;

endmodule

// File: tb/tb_line_buf3.sv
// tb_line_buf3: randomized scoreboard bench for line_buf3 on a 4x4 image.
// The reference model stores the frame as a 2-D array and derives each
// expected triple from rows r-2/r-1/r; a negedge monitor pops and compares.
// With LINEBUF_SOF_EN defined an extra sof restart scenario is exercised.
module tb_line_buf3;
  import linebuf_pkg::*;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [PW-1:0] top;
    logic [PW-1:0] mid;
    logic [PW-1:0] bot;
    logic          sol;
    logic          eof;
  } trip_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  line_buf3_if #(.PIXEL_WIDTH(PW)) bus_if ();

  line_buf3 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  trip_t         exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [PW-1:0] img [H][W];
  int            m_row = 0;
  int            m_col = 0;
  int            sof_epoch = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference: record the pixel in the frame image; rows >= 2 yield a triple.
  function automatic void model_accept(input logic [PW-1:0] p, input logic s);
    trip_t t;
    if (s) begin
      m_row = 0;
      m_col = 0;
      sof_epoch++;
    end
    img[m_row][m_col] = p;
    if (m_row >= 2) begin
      t.top = img[m_row-2][m_col];
      t.mid = img[m_row-1][m_col];
      t.bot = p;
      t.sol = (m_col == 0);
      t.eof = (m_row == H-1) && (m_col == W-1);
      exp_q.push_back(t);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endfunction

  task automatic step(input logic v, input logic [PW-1:0] p, input logic ordy,
                      input logic s, output bit acc);
    bit exp_rdy;
    bus_if.in_valid  = v;
    bus_if.pixel_in  = p;
    bus_if.out_ready = ordy;
`ifdef LINEBUF_SOF_EN
    bus_if.sof = s;
`endif
    @(negedge clk);
    exp_rdy = (m_row < 2) || !bus_if.out_valid || ordy;
    check("in_ready", 32'(bus_if.in_ready), 32'(exp_rdy));
    acc = v && bus_if.in_ready;
    if (acc) model_accept(p, s);
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [PW-1:0] p, input bit rnd, input logic s);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      if (guard > 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
      step(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, p,
           rnd ? ($urandom_range(0, 3) != 0) : 1'b1, s, acc);
      guard++;
    end
  endtask

  task automatic do_reset(input int n);
    rst              = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    bus_if.pixel_in  = 8'hA5;
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    rst   = 1'b0;
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_outputs", 32'({bus_if.pix_top, bus_if.pix_mid, bus_if.pix_bot,
                              bus_if.out_sol, bus_if.out_eof}), 32'd0);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
  endtask

  // Monitor: compare each popped triple, hold-check stalls, count per frame.
  trip_t prev_t;
  bit    prev_stall = 1'b0;
  int    frame_trips = 0;
  int    seen_epoch = 0;
  always @(negedge clk) begin
    trip_t got;
    trip_t e;
    got = {bus_if.pix_top, bus_if.pix_mid, bus_if.pix_bot, bus_if.out_sol, bus_if.out_eof};
    if (rst) begin
      prev_stall  = 1'b0;
      frame_trips = 0;
    end else begin
      if (seen_epoch != sof_epoch) begin
        seen_epoch  = sof_epoch;
        frame_trips = 0;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus_if.out_valid), 32'd1);
        check("stall_hold", 32'(got), 32'(prev_t));
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_triple", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("triple", 32'(got), 32'(e));
          frame_trips++;
          if (e.eof) begin
            check("triples_per_frame", 32'(frame_trips), 32'(W * (H - 2)));
            frame_trips = 0;
          end
        end
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_t     = got;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit sent;
    logic [PW-1:0] p;
    bus_if.in_valid  = 1'b0;
    bus_if.pixel_in  = 8'h00;
    bus_if.out_ready = 1'b1;
`ifdef LINEBUF_SOF_EN
    bus_if.sof = 1'b0;
`endif
    do_reset(2);

    // Frame A: pixel = 16*row + col, full throughput, with directed spot checks.
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_px(8'(16 * r + c), 1'b0, 1'b0);
        if (r == 2 && c == 0) begin
          check("first_triple_valid", 32'(bus_if.out_valid), 32'd1);
          check("first_triple", 32'({bus_if.pix_top, bus_if.pix_mid, bus_if.pix_bot,
                                     bus_if.out_sol, bus_if.out_eof}),
                32'({8'h00, 8'h10, 8'h20, 1'b1, 1'b0}));
        end
        if (r == 3 && c == 3) begin
          check("eof_triple", 32'({bus_if.pix_top, bus_if.pix_mid, bus_if.pix_bot,
                                   bus_if.out_sol, bus_if.out_eof}),
                32'({8'h13, 8'h23, 8'h33, 1'b0, 1'b1}));
        end
      end
    end

    // Frame B back to back with random pixels.
    for (int i = 0; i < W * H; i++) send_px(8'($urandom), 1'b0, 1'b0);

    // Backpressure frame: hold out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < W * H; i++) begin
      p    = 8'(i) ^ 8'h5A;
      sent = 1'b0;
      if (i == 10) begin
        repeat (5) begin
          step(1'b1, p, 1'b0, 1'b0, acc);
          if (acc) sent = 1'b1;
        end
      end
      if (!sent) send_px(p, 1'b0, 1'b0);
    end

    // Two frames with random valid/ready gaps.
    for (int i = 0; i < 2 * W * H; i++) send_px(8'($urandom), 1'b1, 1'b0);

    // Mid-frame reset after 10 accepts, then a clean frame.
    for (int i = 0; i < 10; i++) send_px(8'($urandom), 1'b1, 1'b0);
    do_reset(1);
    for (int i = 0; i < W * H; i++) send_px(8'(8'hC0 + i), 1'b0, 1'b0);

`ifdef LINEBUF_SOF_EN
    // sof at row 2, col 1 restarts priming from that pixel.
    for (int i = 0; i < 9; i++) send_px(8'(i + 1), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    send_px(8'h77, 1'b0, 1'b1);
    check("sof_no_output", 32'(bus_if.out_valid), 32'd0);
    for (int i = 1; i < W * H; i++) send_px(8'(8'h40 + i), 1'b0, 1'b0);
`endif

    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
